// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE, FETCH, DATA, RESP)
//   - GNT_IF/GNT_MEM : owner of the access currently in flight
//   - PERF_CNT_W  : width of the optional performance counters
//   - sat_inc     : saturating increment used by the counters
package mem_arb_pkg;

    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating event counter for arbiter performance statistics.
// Ports:
//   clk   in   clock
//   clear in   synchronous clear (wired to the arbiter reset)
//   en    in   count this cycle
//   cnt   out  current count, sticks at all-ones
module arb_sat_counter
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    output logic [PERF_CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// IF stage (fetch) and the MEM stage (load/store). Data accesses win over
// fetches; a fetch killed by a branch redirect runs to completion on the
// memory side but is never acknowledged.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr/if_kill    fetch request, address, redirect kill
//   if_rdata/if_ack/if_stall  fetched word, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata  data request
//   mem_rdata/mem_ack/mem_stall        load data, completion pulse, stall
//   ram_cs/ram_we/ram_addr/ram_wdata   registered memory command
//   ram_rdata/ram_ready                memory response
//   cnt_if_stall/cnt_mem_stall/cnt_conflict  performance counters
//
// Build option: define ARB_PERF_CNT_EN to enable the performance counters;
// without it the counter ports are tied to zero and no counter flops exist.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_kill,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_ack,
    output logic                  mem_stall,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic                  ram_ready,
    output logic [PERF_CNT_W-1:0] cnt_if_stall,
    output logic [PERF_CNT_W-1:0] cnt_mem_stall,
    output logic [PERF_CNT_W-1:0] cnt_conflict
);

    arb_state_t state;
    logic       owner;
    logic       kill;

    // Stalls must drop in the ack cycle so the stage advances on that edge.
    assign if_stall  = if_req  & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= GNT_IF;
            kill      <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state     <= DATA;
                        owner     <= GNT_MEM;
                        ram_cs    <= 1'b1;
                        ram_we    <= mem_we;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                    end else if (if_req && !if_kill) begin
                        state    <= FETCH;
                        owner    <= GNT_IF;
                        ram_cs   <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= if_addr;
                    end
                end
                FETCH, DATA: begin
                    // A kill in the ready cycle itself must still suppress the ack,
                    // hence the live if_kill term alongside the sticky flag.
                    if (owner == GNT_IF && if_kill) begin
                        kill <= 1'b1;
                    end
                    if (ram_ready) begin
                        ram_cs <= 1'b0;
                        state  <= RESP;
                        if (owner == GNT_IF) begin
                            if_rdata <= ram_rdata;
                            if_ack   <= ~(kill | if_kill);
                        end else begin
                            if (!ram_we) begin
                                mem_rdata <= ram_rdata;
                            end
                            mem_ack <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // No grant here: the requester still holds the request it
                    // is being acked for, and must not be served twice.
                    state <= IDLE;
                    kill  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic conflict;
    assign conflict = (state == IDLE) & if_req & mem_req;

    arb_sat_counter u_cnt_if_stall (
        .clk   (clk),
        .clear (rst),
        .en    (if_stall),
        .cnt   (cnt_if_stall)
    );

    arb_sat_counter u_cnt_mem_stall (
        .clk   (clk),
        .clear (rst),
        .en    (mem_stall),
        .cnt   (cnt_mem_stall)
    );

    arb_sat_counter u_cnt_conflict (
        .clk   (clk),
        .clear (rst),
        .en    (conflict),
        .cnt   (cnt_conflict)
    );
`else
    assign cnt_if_stall  = '0;
    assign cnt_mem_stall = '0;
    assign cnt_conflict  = '0;
`endif

endmodule
